// File: rtl/byte_decode_stream_pkg.sv
// conv_pkg: constants, state type and helpers shared by the ByteDecode
// stream block and its coefficient reduction sub-module.
//   Q              ML-KEM modulus
//   N_COEFFS       coefficients per polynomial
//   MAX_D          widest supported coefficient
//   bytes_per_poly bytes carrying one polynomial of d-bit coefficients
//   state_e        decoder FSM states
package conv_pkg;

  localparam int Q        = 3329;
  localparam int N_COEFFS = 256;
  localparam int MAX_D    = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int bytes_per_poly(input int d);
    return 32 * d;
  endfunction

endpackage

// File: rtl/byte_decode_stream_coef_mod_q.sv
// coef_mod_q: reduces a 12-bit value into [0, Q) with one conditional
// subtract. One subtract is enough because 4095 < 2*Q.
// Ports:
//   coef_i   in   12  unreduced coefficient
//   coef_o   out  12  coef_i mod Q
//   ge_q_o   out  1   coef_i was >= Q (out-of-range encoding)
import conv_pkg::*;

module coef_mod_q (
  input  logic [11:0] coef_i,
  output logic [11:0] coef_o,
  output logic        ge_q_o
);

  localparam logic [11:0] Q12 = 12'(Q);

  assign ge_q_o = (coef_i >= Q12);
  assign coef_o = ge_q_o ? (coef_i - Q12) : coef_i;

endmodule

// File: rtl/byte_decode_stream.sv
// byte_decode_stream: streaming ByteDecode_d. Consumes 32*D bytes on a
// valid/ready byte stream and emits 256 D-bit coefficients in order,
// reduced mod Q when D = 12.
// Optional feature macro: BYTE_DECODE_RANGE_CHECK_EN enables the sticky
// range_err_o flag; without it range_err_o is tied low.
// Ports:
//   clk_i         in   1           clock, rising edge
//   rst_i         in   1           synchronous active-high reset
//   start_i       in   1           begin a frame (IDLE only)
//   byte_i        in   8           input byte, bit 0 is the earliest stream bit
//   byte_valid_i  in   1           byte_i valid
//   byte_ready_o  out  1           byte_i accepted this cycle when valid
//   coef_o        out  COEF_WIDTH  decoded coefficient, zero-extended
//   coef_idx_o    out  8           index of coef_o
//   coef_last_o   out  1           coef_o is index 255
//   coef_valid_o  out  1           coef_o valid
//   coef_ready_i  in   1           consumer accepts coef_o
//   busy_o        out  1           frame in progress
//   done_o        out  1           one-cycle pulse after index 255 transfers
//   range_err_o   out  1           sticky: a D=12 coefficient was >= Q
//
// state | meaning
// IDLE  | waiting for start_i, no handshakes offered
// RUN   | filling the bit accumulator and draining coefficients
import conv_pkg::*;

module byte_decode_stream #(
  parameter int D          = 12,
  parameter int COEF_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [COEF_WIDTH-1:0] coef_o,
  output logic [7:0]            coef_idx_o,
  output logic                  coef_last_o,
  output logic                  coef_valid_o,
  input  logic                  coef_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  range_err_o
);

  if (D < 1 || D > MAX_D) begin : g_bad_d
    $error("byte_decode_stream: D=%0d outside 1..%0d", D, MAX_D);
  end
  if (COEF_WIDTH < D) begin : g_bad_width
    $error("byte_decode_stream: COEF_WIDTH=%0d narrower than D=%0d", COEF_WIDTH, D);
  end

  // Holds at most D-1 leftover bits plus one new byte.
  localparam int ACC_W = D + 7;
  localparam int NB_W  = 5;
  localparam int BC_W  = 9;

  localparam logic [NB_W-1:0] D_NB  = NB_W'(D);
  localparam logic [NB_W-1:0] EIGHT = NB_W'(8);
  localparam logic [BC_W-1:0] BYTES = BC_W'(bytes_per_poly(D));

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [NB_W-1:0]    nbits_q, nbits_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [7:0]         idx_q, idx_d;
  logic               done_q, done_d;

  logic               run;
  logic               byte_xfer;
  logic               coef_xfer;
  logic               start_acc;
  logic               last_xfer;

  assign run       = (state_q == RUN);
  assign byte_xfer = byte_valid_i & byte_ready_o;
  assign coef_xfer = coef_valid_o & coef_ready_i;
  assign start_acc = (state_q == IDLE) & start_i;
  assign last_xfer = coef_xfer & (idx_q == 8'd255);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)   state_d = RUN;
      RUN:     if (last_xfer) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Byte accept needs nbits < D, coefficient pop needs nbits >= D, so the
  // two handshakes can never fire together.
  always_comb begin
    busy_o       = run;
    byte_ready_o = run & (nbits_q < D_NB) & (bcnt_q < BYTES);
    coef_valid_o = run & (nbits_q >= D_NB);
    coef_last_o  = coef_valid_o & (idx_q == 8'd255);
    coef_idx_o   = idx_q;
    done_o       = done_q;
  end

  always_comb begin
    acc_d   = acc_q;
    nbits_d = nbits_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    done_d  = last_xfer;
    if (start_acc) begin
      acc_d   = '0;
      nbits_d = '0;
      bcnt_d  = '0;
      idx_d   = '0;
    end else if (byte_xfer) begin
      // Bits at and above nbits are already zero, so OR places the byte.
      acc_d   = acc_q | (ACC_W'(byte_i) << nbits_q);
      nbits_d = nbits_q + EIGHT;
      bcnt_d  = bcnt_q + 9'd1;
    end else if (coef_xfer) begin
      acc_d   = acc_q >> D;
      nbits_d = nbits_q - D_NB;
      idx_d   = idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      nbits_q <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      nbits_q <= nbits_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  logic [D-1:0] coef_red;
  logic         ge_raw;

  if (D == 12) begin : g_modq
    coef_mod_q u_mod_q (
      .coef_i (acc_q[11:0]),
      .coef_o (coef_red),
      .ge_q_o (ge_raw)
    );
  end else begin : g_plain
    assign coef_red = acc_q[D-1:0];
    assign ge_raw   = 1'b0;
  end

  assign coef_o = COEF_WIDTH'(coef_red);

`ifdef BYTE_DECODE_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q;
    if (start_acc) begin
      range_err_d = 1'b0;
    end else if (coef_xfer && ge_raw) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err_o = range_err_q;
`else
  logic unused_ge;
  assign unused_ge   = ge_raw;
  assign range_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_byte_decode_stream.sv
module tb_byte_decode_stream;

  localparam int NI = 5;
  localparam int QM = 3329;

`ifdef BYTE_DECODE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_i      [NI];
  logic [7:0]  byte_i       [NI];
  logic        byte_valid_i [NI];
  logic        coef_ready_i [NI];
  logic        byte_ready_w [NI];
  logic [15:0] coef_w       [NI];
  logic [7:0]  idx_w        [NI];
  logic        last_w       [NI];
  logic        coef_valid_w [NI];
  logic        busy_w       [NI];
  logic        done_w       [NI];
  logic        err_w        [NI];

  always #5 clk = ~clk;

  // Instance k decodes with D = d_of(k).
  function automatic int d_of(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 10;
      3: return 11;
      default: return 12;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 10 : (g == 3) ? 11 : 12;
    byte_decode_stream #(.D(DG), .COEF_WIDTH(16)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start_i[g]),
      .byte_i       (byte_i[g]),
      .byte_valid_i (byte_valid_i[g]),
      .byte_ready_o (byte_ready_w[g]),
      .coef_o       (coef_w[g]),
      .coef_idx_o   (idx_w[g]),
      .coef_last_o  (last_w[g]),
      .coef_valid_o (coef_valid_w[g]),
      .coef_ready_i (coef_ready_i[g]),
      .busy_o       (busy_w[g]),
      .done_o       (done_w[g]),
      .range_err_o  (err_w[g])
    );
  end

  logic [7:0]  in_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  obs_idx_q[$];
  logic [15:0] src_q[$];
  int          done_cnt, stab_err, last_err, bytes_acc;
  bit          timeout;
  logic        err_seen;
  bit          exp_err;
  int          checks = 0;
  int          failures = 0;

  // Reference decode straight from the bit-mapping definition.
  task automatic model_decode(input int d);
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      int raw = 0;
      for (int j = 0; j < d; j++) begin
        int s = i * d + j;
        if (in_q[s / 8][s % 8]) raw = raw | (1 << j);
      end
      if (d == 12 && raw >= QM) begin
        raw = raw - QM;
        exp_err = 1'b1;
      end
      exp_q.push_back(16'(raw));
    end
  endtask

  // ByteEncode_d of src_q into in_q; expected output is src_q itself.
  task automatic encode_src(input int d);
    in_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
    for (int b = 0; b < 32 * d; b++) in_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < d; j++) begin
        int s = i * d + j;
        if (src_q[i][j]) in_q[s / 8] = in_q[s / 8] | 8'(1 << (s % 8));
      end
      exp_q.push_back(src_q[i]);
    end
  endtask

  task automatic random_bytes(input int d);
    in_q.delete();
    for (int b = 0; b < 32 * d; b++) in_q.push_back(8'($urandom));
  endtask

  // Runs one frame on instance k, recording every coefficient transfer.
  task automatic drive_frame(input int k, input int gap, input int stall,
                             input int stop_after, input bit poke_start);
    int          bi, cyc, post;
    logic        hold;
    logic [15:0] hc;
    logic [7:0]  hi;
    bi = 0; cyc = 0; post = 0; hold = 1'b0; hc = '0; hi = '0;
    obs_q.delete(); obs_idx_q.delete();
    done_cnt = 0; stab_err = 0; last_err = 0; timeout = 1'b0;
    start_i[k] = 1'b1;
    @(posedge clk); #1;
    start_i[k] = 1'b0;
    forever begin
      if (done_w[k]) done_cnt++;
      if (hold && (!coef_valid_w[k] || coef_w[k] !== hc || idx_w[k] !== hi)) stab_err++;
      if (done_cnt > 0) post++;
      if (post >= 4) break;
      if (stop_after > 0 && obs_q.size() >= stop_after) break;
      if (cyc >= 20000) begin
        timeout = 1'b1;
        break;
      end
      start_i[k]      = poke_start && done_cnt == 0 && ($urandom_range(9) == 0);
      byte_valid_i[k] = ($urandom_range(99) >= gap);
      byte_i[k]       = (bi < in_q.size()) ? in_q[bi] : 8'hEE;
      coef_ready_i[k] = ($urandom_range(99) >= stall);
      if (byte_valid_i[k] && byte_ready_w[k]) bi++;
      if (coef_valid_w[k] && coef_ready_i[k]) begin
        obs_q.push_back(coef_w[k]);
        obs_idx_q.push_back(idx_w[k]);
        if ((idx_w[k] == 8'd255) !== last_w[k]) last_err++;
      end
      hold = coef_valid_w[k] && !coef_ready_i[k];
      hc   = coef_w[k];
      hi   = idx_w[k];
      @(posedge clk); #1;
      cyc++;
    end
    start_i[k]      = 1'b0;
    byte_valid_i[k] = 1'b0;
    coef_ready_i[k] = 1'b0;
    bytes_acc       = bi;
    err_seen        = err_w[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({busy_w[k], byte_ready_w[k], coef_valid_w[k], last_w[k], done_w[k], err_w[k],
           coef_w[k], idx_w[k]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d busy=%b rdy=%b val=%b coef=%0d idx=%0d exp all 0",
                 k, busy_w[k], byte_ready_w[k], coef_valid_w[k], coef_w[k], idx_w[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    start_i[0] = 1'b1; start_i[4] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0; start_i[4] = 1'b0;
    checks++;
    if (busy_w[4] !== 1'b1 || byte_ready_w[4] !== 1'b1 || coef_valid_w[4] !== 1'b0) begin
      failures++;
      $display("FAIL latency_start busy=%b rdy=%b val=%b exp 1 1 0", busy_w[4], byte_ready_w[4], coef_valid_w[4]);
    end
    byte_valid_i[0] = 1'b1; byte_i[0] = 8'h12;
    byte_valid_i[4] = 1'b1; byte_i[4] = 8'h12;
    @(posedge clk); #1;
    byte_valid_i[0] = 1'b0;
    checks++;
    if (coef_valid_w[0] !== 1'b1 || byte_ready_w[0] !== 1'b0 || coef_w[0] !== 16'd0 || idx_w[0] !== 8'd0) begin
      failures++;
      $display("FAIL latency_d1 val=%b rdy=%b coef=%0d idx=%0d exp 1 0 0 0",
               coef_valid_w[0], byte_ready_w[0], coef_w[0], idx_w[0]);
    end
    checks++;
    if (coef_valid_w[4] !== 1'b0 || byte_ready_w[4] !== 1'b1) begin
      failures++;
      $display("FAIL latency_d12_one_byte val=%b rdy=%b exp 0 1", coef_valid_w[4], byte_ready_w[4]);
    end
    @(posedge clk); #1;
    byte_valid_i[4] = 1'b0;
    checks++;
    if (coef_valid_w[4] !== 1'b1 || byte_ready_w[4] !== 1'b0 || coef_w[4] !== 16'h0212) begin
      failures++;
      $display("FAIL latency_d12_two_bytes val=%b rdy=%b coef=%h exp 1 0 0212",
               coef_valid_w[4], byte_ready_w[4], coef_w[4]);
    end
    // Both instances are mid-frame; clear them for the following tests.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy_w[4] !== 1'b0 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_reset_idle busy0=%b busy4=%b exp 0 0", busy_w[0], busy_w[4]);
    end
  endtask

  task automatic test_d1_pattern();
    logic [7:0] pat;
    pat = 8'b1010_0101;
    in_q.delete();
    in_q.push_back(8'hA5);
    for (int b = 1; b < 32; b++) in_q.push_back(8'h00);
    exp_q.delete();
    exp_err = 1'b0;
    foreach (pat[b]) exp_q.push_back(16'(pat[7 - b]));
    for (int i = 8; i < 256; i++) exp_q.push_back(16'd0);
    drive_frame(0, 0, 0, 0, 1'b0);
    checks++;
    if (timeout || obs_q.size() != 256) begin
      failures++;
      $display("FAIL d1_count got=%0d exp=256 timeout=%0d", obs_q.size(), timeout);
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      logic [15:0] e, o;
      logic [7:0]  oi;
      e = exp_q.pop_front(); o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
      checks++;
      if (o !== e || oi !== 8'(i)) begin
        failures++;
        $display("FAIL d1_coef i=%0d got=%0d idx=%0d exp=%0d", i, o, oi, e);
        break;
      end
    end
    checks++;
    if (done_cnt !== 1 || bytes_acc !== 32 || last_err !== 0) begin
      failures++;
      $display("FAIL d1_frame done=%0d bytes=%0d last_err=%0d exp 1 32 0", done_cnt, bytes_acc, last_err);
    end
  endtask

  task automatic test_d12_vectors();
    logic [7:0] pats [3][3];
    pats[0] = '{8'hFF, 8'hFF, 8'hFF};
    pats[1] = '{8'h01, 8'h10, 8'h00};
    pats[2] = '{8'h01, 8'h0D, 8'hD0};
    for (int p = 0; p < 3; p++) begin
      in_q.delete();
      for (int r = 0; r < 128; r++)
        for (int b = 0; b < 3; b++) in_q.push_back(pats[p][b]);
      model_decode(12);
      drive_frame(4, 0, 0, 0, 1'b0);
      checks++;
      if (timeout || obs_q.size() != 256) begin
        failures++;
        $display("FAIL d12_vec%0d_count got=%0d exp=256 timeout=%0d", p, obs_q.size(), timeout);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
        logic [15:0] e, o;
        logic [7:0]  oi;
        e = exp_q.pop_front(); o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
        checks++;
        if (o !== e || oi !== 8'(i)) begin
          failures++;
          $display("FAIL d12_vec%0d_coef i=%0d got=%0d idx=%0d exp=%0d", p, i, o, oi, e);
          break;
        end
      end
      checks++;
      if (done_cnt !== 1 || bytes_acc !== 384 || last_err !== 0) begin
        failures++;
        $display("FAIL d12_vec%0d_frame done=%0d bytes=%0d last_err=%0d exp 1 384 0",
                 p, done_cnt, bytes_acc, last_err);
      end
      checks++;
      if (err_seen !== (RC & exp_err)) begin
        failures++;
        $display("FAIL d12_vec%0d_range_err got=%b exp=%b", p, err_seen, RC & exp_err);
      end
    end
  endtask

  task automatic test_roundtrip();
    for (int k = 1; k < NI; k++) begin
      int d;
      d = d_of(k);
      src_q.delete();
      for (int i = 0; i < 256; i++)
        src_q.push_back(16'((d == 12) ? $urandom_range(QM - 1) : $urandom_range((1 << d) - 1)));
      encode_src(d);
      drive_frame(k, 0, 0, 0, 1'b0);
      checks++;
      if (timeout || obs_q.size() != 256) begin
        failures++;
        $display("FAIL rt_d%0d_count got=%0d exp=256 timeout=%0d", d, obs_q.size(), timeout);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
        logic [15:0] e, o;
        logic [7:0]  oi;
        e = exp_q.pop_front(); o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
        checks++;
        if (o !== e || oi !== 8'(i)) begin
          failures++;
          $display("FAIL rt_d%0d_coef i=%0d got=%0d idx=%0d exp=%0d", d, i, o, oi, e);
          break;
        end
      end
      checks++;
      if (done_cnt !== 1 || bytes_acc !== 32 * d || err_seen !== 1'b0) begin
        failures++;
        $display("FAIL rt_d%0d_frame done=%0d bytes=%0d err=%b exp 1 %0d 0",
                 d, done_cnt, bytes_acc, err_seen, 32 * d);
      end
    end
  endtask

  task automatic test_stalls();
    int ks [2];
    ks = '{4, 2};
    foreach (ks[n]) begin
      int k, d;
      k = ks[n];
      d = d_of(k);
      random_bytes(d);
      model_decode(d);
      drive_frame(k, 50, 50, 0, 1'b1);
      checks++;
      if (timeout || obs_q.size() != 256) begin
        failures++;
        $display("FAIL stall_d%0d_count got=%0d exp=256 timeout=%0d", d, obs_q.size(), timeout);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
        logic [15:0] e, o;
        logic [7:0]  oi;
        e = exp_q.pop_front(); o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
        checks++;
        if (o !== e || oi !== 8'(i)) begin
          failures++;
          $display("FAIL stall_d%0d_coef i=%0d got=%0d idx=%0d exp=%0d", d, i, o, oi, e);
          break;
        end
      end
      checks++;
      if (stab_err !== 0 || last_err !== 0 || done_cnt !== 1 || bytes_acc !== 32 * d) begin
        failures++;
        $display("FAIL stall_d%0d_frame stab=%0d last=%0d done=%0d bytes=%0d exp 0 0 1 %0d",
                 d, stab_err, last_err, done_cnt, bytes_acc, 32 * d);
      end
      checks++;
      if (err_seen !== (RC & exp_err && d == 12)) begin
        failures++;
        $display("FAIL stall_d%0d_range_err got=%b exp=%b", d, err_seen, RC & exp_err && d == 12);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    random_bytes(10);
    model_decode(10);
    drive_frame(2, 20, 20, 100, 1'b0);
    checks++;
    if (obs_q.size() != 100 || busy_w[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_partial got=%0d busy=%b exp 100 1", obs_q.size(), busy_w[2]);
    end
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [15:0] e, o;
      logic [7:0]  oi;
      e = exp_q.pop_front(); o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
      checks++;
      if (o !== e || oi !== 8'(i)) begin
        failures++;
        $display("FAIL mid_partial_coef i=%0d got=%0d idx=%0d exp=%0d", i, o, oi, e);
        break;
      end
    end
    rst = 1'b1;
    byte_valid_i[2] = 1'b1;
    coef_ready_i[2] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_w[2], byte_ready_w[2], coef_valid_w[2], last_w[2], done_w[2], err_w[2],
         coef_w[2], idx_w[2]} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs busy=%b rdy=%b val=%b coef=%0d idx=%0d exp all 0",
               busy_w[2], byte_ready_w[2], coef_valid_w[2], coef_w[2], idx_w[2]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    byte_valid_i[2] = 1'b0;
    coef_ready_i[2] = 1'b0;
    @(posedge clk); #1;
    random_bytes(10);
    model_decode(10);
    drive_frame(2, 0, 0, 0, 1'b0);
    checks++;
    if (timeout || obs_q.size() != 256) begin
      failures++;
      $display("FAIL mid_fresh_count got=%0d exp=256 timeout=%0d", obs_q.size(), timeout);
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      logic [15:0] e, o;
      logic [7:0]  oi;
      e = exp_q.pop_front(); o = obs_q.pop_front(); oi = obs_idx_q.pop_front();
      checks++;
      if (o !== e || oi !== 8'(i)) begin
        failures++;
        $display("FAIL mid_fresh_coef i=%0d got=%0d idx=%0d exp=%0d", i, o, oi, e);
        break;
      end
    end
    checks++;
    if (done_cnt !== 1 || bytes_acc !== 320) begin
      failures++;
      $display("FAIL mid_fresh_frame done=%0d bytes=%0d exp 1 320", done_cnt, bytes_acc);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      start_i[k]      = 1'b0;
      byte_i[k]       = 8'h00;
      byte_valid_i[k] = 1'b0;
      coef_ready_i[k] = 1'b0;
    end
    test_reset();
    test_latency();
    test_d1_pattern();
    test_d12_vectors();
    test_roundtrip();
    test_stalls();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
